// File: rtl/mult4_pkg.sv
// Shared definitions for the sequential 4x4 shift/add multiplier:
// controller state encoding, operand/product widths and the last iteration index.
package mult4_pkg;

    localparam int OPW   = 4;
    localparam int PRODW = 8;

    // Counter value on the edge that performs the fourth (final) iteration
    localparam logic [2:0] ITER_LAST = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder4.sv
// 4-bit ripple-carry adder feeding the multiplier accumulator.
module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    // Widen to 5 bits so the carry out of bit 3 is kept
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};

endmodule

// File: rtl/shift_add_mult4.sv
// Sequential 4x4 unsigned multiplier: four add/shift iterations through one
// shared adder4, start/busy/done handshake, registered 8-bit product.
// Optional build macro MULT4_ZERO_BYPASS_EN: a zero operand skips the
// iterations and goes straight to DONE with a zero product.
module shift_add_mult4
    import mult4_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic             busy,
    output logic             done,
    output logic [PRODW-1:0] product
);

    state_t state_reg, state_next;

    logic [OPW-1:0]   m_reg;
    logic [OPW-1:0]   acc_reg;
    logic             c_reg;
    logic [OPW-1:0]   q_reg;
    logic [2:0]       cnt_reg;
    logic [PRODW-1:0] product_reg;

    logic [OPW-1:0]   add_sum;
    logic             add_cout;
    logic [OPW-1:0]   iter_acc;
    logic             iter_c;
    logic             zero_operand;

    adder4 u_adder4 (
        .a     (acc_reg),
        .b     (m_reg),
        .c_in  (1'b0),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    assign zero_operand = (a == '0) || (b == '0);

    // Select the add result or the untouched accumulator depending on Q[0]
    always_comb begin
        iter_acc = acc_reg;
        iter_c   = c_reg;
        if (q_reg[0]) begin
            iter_acc = add_sum;
            iter_c   = add_cout;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
`ifdef MULT4_ZERO_BYPASS_EN
                    state_next = zero_operand ? S_DONE : S_CALC;
`else
                    state_next = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (cnt_reg == ITER_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        busy = (state_reg != S_IDLE);
        done = (state_reg == S_DONE);
    end

    // Datapath: operand capture in IDLE, one add/shift per CALC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg       <= '0;
            acc_reg     <= '0;
            c_reg       <= 1'b0;
            q_reg       <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        m_reg   <= a;
                        q_reg   <= b;
                        acc_reg <= '0;
                        c_reg   <= 1'b0;
                        cnt_reg <= '0;
`ifdef MULT4_ZERO_BYPASS_EN
                        if (zero_operand) begin
                            product_reg <= '0;
                        end
`endif
                    end
                end
                S_CALC: begin
                    // Shift {C,A,Q} right: carry enters A[3], A[0] enters Q[3]
                    acc_reg <= {iter_c, iter_acc[OPW-1:1]};
                    q_reg   <= {iter_acc[0], q_reg[OPW-1:1]};
                    c_reg   <= 1'b0;
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg == ITER_LAST) begin
                        product_reg <= {iter_c, iter_acc, q_reg[OPW-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign product = product_reg;

endmodule
